// File: rtl/ff_pkg.sv
// Shared constants and types for the accelerator load-port transmitter.
// Holds the stream markers, the section encoding and the transmit FSM states.
package ff_pkg;

    localparam logic [31:0] MK_BIAS   = 32'h8000_0000;
    localparam logic [31:0] MK_NEURON = 32'hFFFF_FFFF;
    localparam logic [31:0] MK_END    = 32'hFFFF_FFF0;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        SECT_W = 2'd0,
        SECT_B = 2'd1,
        SECT_I = 2'd2
    } sect_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_W,
        ST_MK_B,
        ST_SEND_B,
        ST_MK_N,
        ST_SEND_I,
        ST_MK_E,
        ST_START,
        ST_DONE
    } tx_state_t;

    // True when a payload word would be mistaken for a framing marker by the accelerator.
    function automatic logic is_bad_marker(input logic [31:0] d);
        return (d == MK_NEURON) || (d == MK_END);
    endfunction

    function automatic logic [31:0] sanitize(input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (d == MK_BIAS)
            r = 32'h0000_0000;
        else if (is_bad_marker(d))
            r = QNAN;
        return r;
    endfunction

endpackage

// File: rtl/ff_tx_buf.sv
// Single-port DEPTHx32 word buffer, one-cycle registered read; no backpressure.
// Read data holds its last value while en is low, which lets the prefetched word survive marker cycles.
module ff_tx_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ff_load_tx.sv
// Buffers host words (valid/ready, stalls when busy or full) and replays them as one marker-framed stream.
// Latency: go at G -> load G+1, first word G+2, end marker G+4+N, start +1, done +2; stream never stalls.
module ff_load_tx
    import ff_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_sect,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ff_data,
    output logic        ff_load,
    output logic        ff_start
);

    localparam logic [AW-1:0] CAP = AW'(DEPTH - 3);

    tx_state_t     state, state_nx;
    logic [AW-1:0] nw, nb, ni;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    last_sect;
    logic [AW-1:0] end_w, end_b, end_i;

    logic          accept, bad_sect, store, set_err;
    logic          rd_en;
    logic          buf_en;
    logic [AW-1:0] buf_addr;
    logic [31:0]   buf_rdata;

    // ---------------- fill side ----------------
    assign in_ready = !rst && (state == ST_IDLE) && (wr_ptr < CAP);
    assign accept   = in_valid && in_ready;
    assign bad_sect = (in_sect == 2'd3) || (in_sect < last_sect);
    assign store    = accept && !bad_sect;
    assign set_err  = accept && (bad_sect || is_bad_marker(in_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nw        <= '0;
            nb        <= '0;
            ni        <= '0;
            wr_ptr    <= '0;
            last_sect <= 2'd0;
        end else if (state == ST_DONE) begin
            nw        <= '0;
            nb        <= '0;
            ni        <= '0;
            wr_ptr    <= '0;
            last_sect <= 2'd0;
        end else if (store) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_sect <= in_sect;
            if (in_sect == SECT_W)
                nw <= nw + 1'b1;
            else if (in_sect == SECT_B)
                nb <= nb + 1'b1;
            else
                ni <= ni + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (set_err)
            err <= 1'b1;
    end

    // ---------------- buffer ----------------
    // Write port owns the RAM in IDLE; afterwards the read pointer does.
    assign buf_addr = (state == ST_IDLE) ? wr_ptr : rd_ptr;
    assign buf_en   = store || rd_en;

    ff_tx_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .en    (buf_en),
        .we    (store),
        .addr  (buf_addr),
        .wdata (sanitize(in_data)),
        .rdata (buf_rdata)
    );

    // Read pointer always runs one word ahead of the word on ff_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_ptr <= '0;
        else if (state == ST_IDLE)
            rd_ptr <= '0;
        else if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
    end

    assign end_w = nw;
    assign end_b = nw + nb;
    assign end_i = nw + nb + ni;

    // ---------------- transmit FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        ff_data  = 32'h0;
        case (state)
            ST_IDLE: begin
                if (go)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                rd_en    = 1'b1;
                state_nx = (nw != '0) ? ST_SEND_W : ST_MK_B;
            end
            ST_SEND_W: begin
                rd_en   = 1'b1;
                ff_data = buf_rdata;
                if (rd_ptr == end_w)
                    state_nx = ST_MK_B;
            end
            ST_MK_B: begin
                ff_data  = MK_BIAS;
                state_nx = (nb != '0) ? ST_SEND_B : ST_MK_N;
            end
            ST_SEND_B: begin
                rd_en   = 1'b1;
                ff_data = buf_rdata;
                if (rd_ptr == end_b)
                    state_nx = ST_MK_N;
            end
            ST_MK_N: begin
                ff_data  = MK_NEURON;
                state_nx = (ni != '0) ? ST_SEND_I : ST_MK_E;
            end
            ST_SEND_I: begin
                rd_en   = 1'b1;
                ff_data = buf_rdata;
                if (rd_ptr == end_i)
                    state_nx = ST_MK_E;
            end
            ST_MK_E: begin
                ff_data  = MK_END;
                state_nx = ST_START;
            end
            ST_START: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            ff_load  <= 1'b0;
            ff_start <= 1'b0;
        end else begin
            busy     <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
            done     <= (state_nx == ST_DONE);
            ff_load  <= (state_nx == ST_LOAD);
            ff_start <= (state_nx == ST_START);
        end
    end

endmodule

// File: tb/tb_ff_load_tx.sv
// Directed bench for ff_load_tx: fills the buffer, replays frames and checks every stream cycle.
// Expected frames are built by hand from the pushed words and the marker constants.
module tb_ff_load_tx;
    import ff_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_sect = 2'd0;
    logic        go = 1'b0;
    logic        in_ready, busy, done, err, ff_load, ff_start;
    logic [31:0] ff_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];
    logic [31:0] fv[9];

    ff_load_tx dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sect  (in_sect),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ff_data  (ff_data),
        .ff_load  (ff_load),
        .ff_start (ff_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sect  = s;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            chk("push_stall", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int ghost_at);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("load", ff_load, 1);
        chk("load_busy", busy, 1);
        chk("load_rdy", in_ready, 0);
        chk("load_dat", ff_data, 0);
        for (int i = 0; i < expq.size(); i++) begin
            @(negedge clk);
            go = (i == ghost_at);
            chk($sformatf("word%0d", i), ff_data, expq[i]);
            if (i == 0)
                chk("load_width", ff_load, 0);
        end
        go = 1'b0;
        @(negedge clk);
        chk("start", ff_start, 1);
        chk("start_dat", ff_data, 0);
        chk("start_busy", busy, 1);
        @(negedge clk);
        chk("done", done, 1);
        chk("start_width", ff_start, 0);
        chk("done_busy", busy, 0);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("idle_rdy", in_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        fv[0] = 32'h3F80_0000; fv[1] = 32'h4000_0000; fv[2] = 32'h4040_0000;
        fv[3] = 32'h4080_0000; fv[4] = 32'h40A0_0000; fv[5] = 32'h40C0_0000;
        fv[6] = 32'h40E0_0000; fv[7] = 32'h4100_0000; fv[8] = 32'h4110_0000;

        #1;
        chk("rst_rdy", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dat", ff_data, 0);
        chk("rst_load", ff_load, 0);
        chk("rst_start", ff_start, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy", in_ready, 1);

        // 4 weights, 2 biases, 3 inputs
        for (int i = 0; i < 4; i++) push(2'd0, fv[i]);
        for (int i = 4; i < 6; i++) push(2'd1, fv[i]);
        for (int i = 6; i < 9; i++) push(2'd2, fv[i]);
        expq = '{fv[0], fv[1], fv[2], fv[3], MK_BIAS, fv[4], fv[5],
                 MK_NEURON, fv[6], fv[7], fv[8], MK_END};
        run_frame(-1);
        chk("f1_err", err, 0);

        // empty frame
        expq = '{MK_BIAS, MK_NEURON, MK_END};
        run_frame(-1);

        // full buffer, with a stray go during SEND_W
        for (int i = 0; i < 509; i++)
            push((i < 200) ? 2'd0 : (i < 400) ? 2'd1 : 2'd2, 32'h4000_0000 + i);
        @(negedge clk);
        chk("full_rdy", in_ready, 0);
        in_valid = 1'b1; in_sect = 2'd2; in_data = 32'h1234_5678;
        repeat (3) @(negedge clk);
        chk("full_hold_rdy", in_ready, 0);
        in_valid = 1'b0;
        expq.delete();
        for (int i = 0; i < 200; i++) expq.push_back(32'h4000_0000 + i);
        expq.push_back(MK_BIAS);
        for (int i = 200; i < 400; i++) expq.push_back(32'h4000_0000 + i);
        expq.push_back(MK_NEURON);
        for (int i = 400; i < 509; i++) expq.push_back(32'h4000_0000 + i);
        expq.push_back(MK_END);
        run_frame(5);
        chk("full_err", err, 0);
        @(negedge clk);
        chk("ghost_go_idle", busy, 0);

        // marker sanitising
        push(2'd1, MK_BIAS);
        chk("san_err0", err, 0);
        push(2'd2, MK_END);
        chk("san_err1", err, 1);
        expq = '{MK_BIAS, 32'h0000_0000, MK_NEURON, QNAN, MK_END};
        run_frame(-1);

        // section regression
        do_reset();
        chk("reset_err", err, 0);
        push(2'd0, fv[0]);
        push(2'd1, fv[1]);
        chk("reg_err0", err, 0);
        push(2'd0, fv[2]);
        chk("reg_err1", err, 1);
        expq = '{fv[0], MK_BIAS, fv[1], MK_NEURON, MK_END};
        run_frame(-1);

        // reset during SEND_B
        do_reset();
        for (int i = 0; i < 3; i++) push(2'd0, fv[i]);
        for (int i = 3; i < 6; i++) push(2'd1, fv[i]);
        push(2'd2, fv[6]);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_sendb", ff_data, fv[3]);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_dat", ff_data, 0);
        chk("mid_load", ff_load, 0);
        chk("mid_start", ff_start, 0);
        chk("mid_done", done, 0);
        chk("mid_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        chk("mid_edge_busy", busy, 0);
        chk("mid_edge_dat", ff_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_rdy", in_ready, 1);
        push(2'd0, fv[8]);
        push(2'd2, fv[7]);
        expq = '{fv[8], MK_BIAS, MK_NEURON, fv[7], MK_END};
        run_frame(-1);
        chk("mid_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_load_tx.md
# ff_load_tx

Stream transmitter for the feed-forward accelerator's load port. The host pushes weight, bias and input-neuron words into an on-chip buffer through a valid/ready interface. On `go`, the block replays them to the accelerator as one gap-free, marker-framed stream, then pulses the accelerator's start input. It sits between the host/bus adapter and the accelerator's `data`/`load`/`start` pins, and is the sending end of that load protocol.

## Interface
- `DEPTH`, 512 — buffer capacity in words, sized to the accelerator's 9-bit SRAM address; payload limit is DEPTH-3.
- `AW`, 9 — buffer address width, equal to clog2(DEPTH).

- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `in_valid` in 1 — host word valid.
- `in_ready` out 1 — block accepts a word this cycle.
- `in_data` in 32 — IEEE-754 single-precision payload word.
- `in_sect` in 2 — section of the word: 0 = weight, 1 = bias, 2 = input neuron, 3 = illegal.
- `go` in 1 — start transmission; single-cycle pulse.
- `busy` out 1 — transmission in progress.
- `done` out 1 — one-cycle pulse when the frame and start pulse have been sent.
- `err` out 1 — sticky error flag; cleared only by `rst`.
- `ff_data` out 32 — to accelerator `data`.
- `ff_load` out 1 — to accelerator `load`.
- `ff_start` out 1 — to accelerator `start`.

## Operation
- Fill (IDLE):
  - A word is accepted when `in_valid && in_ready`.
  - `in_ready` is combinational: state==IDLE and stored count < DEPTH-3.
  - Sections must arrive in non-decreasing order (W, then B, then I).
  - A regression or `in_sect`=3 drops the word and sets `err`.
  - Per-section counters `nw`, `nb`, `ni` (AW bits each) increment on accepted words. Words are stored contiguously from address 0.
- Marker sanitising on accept:
  - 0x80000000 (-0.0) is stored as 0x00000000.
  - 0xFFFFFFFF and 0xFFFFFFF0 are stored as 0x7FC00000 and set `err`.
  - All other words are stored unchanged.
- FSM states: IDLE → LOAD → SEND_W → MK_B → SEND_B → MK_N → SEND_I → MK_E → START → DONE → IDLE.
  - IDLE→LOAD on `go`. `go` is ignored in every other state.
  - LOAD: `ff_load`=1; issue buffer read of address 0.
  - SEND_x: drive one buffered word per cycle for count cycles. Zero-count sections are skipped directly to the following marker state.
  - MK_B drives 0x80000000; MK_N drives 0xFFFFFFFF; MK_E drives 0xFFFFFFF0.
  - START: `ff_start`=1.
  - DONE: `done`=1. Clear `nw`, `nb`, `ni` and the write pointer; return to IDLE.
- The stream must never stall or bubble. The accelerator samples `data` every cycle after `load`, with no valid signal. The buffer read is prefetched one cycle ahead.
- `ff_data` is 0 whenever not in SEND_x or MK_x.

## Timing
- Reset values: `in_ready`=0 while `rst` is high (1 in IDLE after release); `busy`=0, `done`=0, `err`=0, `ff_data`=0, `ff_load`=0, `ff_start`=0. Counters and FSM return to IDLE.
- With `go` sampled at cycle G:
  - LOAD is cycle G+1.
  - The first stream word is at G+2.
  - The end marker is at E = G+2+N+2, where N = nw+nb+ni. The three markers occupy N+3 cycles starting at G+2.
  - `ff_start` is at E+1 and `done` at E+2.
- `busy`=1 from LOAD through START inclusive.
- `ff_load` and `ff_start` are exactly one cycle wide and registered.
- Reset mid-frame:
  - All outputs drop asynchronously; the buffer contents are lost and the counts are cleared.
  - The accelerator must be reset with the same `rst`.
- A push attempted when `in_valid`=1 while busy gets `in_ready`=0; the host holds the word until accepted.
- Capacity: when the count reaches DEPTH-3, `in_ready`=0. No overflow and no wrap-around is possible.

## Structure
- Package `ff_pkg`: marker constants MK_BIAS=32'h80000000, MK_NEURON=32'hFFFFFFFF, MK_END=32'hFFFFFFF0, QNAN=32'h7FC00000; section enum (SECT_W, SECT_B, SECT_I); tx state enum.
- Sub-module `ff_tx_buf`: single-port synchronous RAM, DEPTH×32, 1-cycle read latency. It takes the write port in IDLE and the read port otherwise.

## Test plan
- Push 4 weights, 2 biases and 3 inputs (values 1.0–9.0), then `go`. Required: `ff_load` one cycle, then 12 consecutive words W1–W4, 0x80000000, B1–B2, 0xFFFFFFFF, I1–I3, 0xFFFFFFF0; `ff_start` one cycle later, then `done`; `err`=0.
- Empty buffer, `go`. Required: stream 0x80000000, 0xFFFFFFFF, 0xFFFFFFF0 at G+2..G+4; `ff_start` at G+5.
- Push bias 0x80000000 and input 0xFFFFFFF0. Required: transmitted as 0x00000000 and 0x7FC00000; `err`=1 (second word only).
- Push weight, bias, then weight. Required: the third word is dropped and `err`=1; the frame carries 1 weight and 1 bias.
- Push 509 words. Required: `in_ready`=0 afterward; frame length is 512 words; a `go` pulse during SEND_W is ignored.
- Assert `rst` mid-SEND_B. Required: all outputs are 0 next edge; a new fill and `go` produces a correct frame.
